bcd_count_sequencer: RTL and testbench

- Controller that sequences a 4-digit BCD counter chain from 0000 up to a programmable terminal value (default 9675).
- Generates the per-digit enable/carry ripple from a prescaled count tick.
- Handles run, pause and clear commands, and flags the terminal count.
- Sits above the single-digit counter cells and owns the digit registers, the prescaler and the control state.

---
 rtl/bcd_count_sequencer.sv | 141 ++++++++++++++
 tb/tb_bcd_count_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_count_sequencer.sv
// Four-digit BCD count sequencer: prescaled tick, digit ripple with per-digit carry,
// run/pause/clear control and terminal-count flag (wrap or stop at LIMIT).
module bcd_count_sequencer #(
    parameter int unsigned PRESCALE  = 4,
    parameter logic [15:0] LIMIT     = 16'h9675,
    parameter bit          AUTO_WRAP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    output logic [15:0] qbcd,
    output logic [3:0]  carry,
    output logic        tick,
    output logic        running,
    output logic        flag
);

    localparam int unsigned PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] pre;
    logic [PW-1:0] pre_next;
    logic [15:0]   qbcd_next;
    logic [3:0]    carry_next;
    logic          tick_next;
    logic          flag_next;
    logic [15:0]   inc_val;
    logic [3:0]    inc_carry;
    logic          ripple;

    // BCD +1: each digit at 9 rolls to 0 and passes the increment upward
    always_comb begin
        inc_val   = qbcd;
        inc_carry = 4'b0000;
        ripple    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (ripple) begin
                if (qbcd[4*i +: 4] == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                    inc_carry[i]      = 1'b1;
                end else begin
                    inc_val[4*i +: 4] = qbcd[4*i +: 4] + 4'd1;
                    ripple            = 1'b0;
                end
            end
        end
    end

    // Next state, prescaler and registered-output values; clear > stop > start
    always_comb begin
        state_next = state;
        pre_next   = pre;
        qbcd_next  = qbcd;
        carry_next = 4'b0000;
        tick_next  = 1'b0;
        flag_next  = AUTO_WRAP ? 1'b0 : flag;

        if (clear) begin
            state_next = IDLE;
            pre_next   = '0;
            qbcd_next  = 16'h0000;
            flag_next  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pre_next = '0;
                    if (!stop && start) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_next = PAUSE;
                    end else if (pre == PRE_LAST) begin
                        pre_next = '0;
                        if (qbcd == LIMIT) begin
                            flag_next = 1'b1;
                            if (AUTO_WRAP) begin
                                qbcd_next = 16'h0000;
                                tick_next = 1'b1;
                            end else begin
                                state_next = DONE;
                            end
                        end else begin
                            qbcd_next  = inc_val;
                            carry_next = inc_carry;
                            tick_next  = 1'b1;
                        end
                    end else begin
                        pre_next = pre + PW'(1);
                    end
                end
                PAUSE: begin
                    if (!stop && start) begin
                        state_next = RUN;
                    end
                end
                DONE: begin
                    pre_next = '0;
                end
                default: begin
                    state_next = IDLE;
                    pre_next   = '0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pre     <= '0;
            qbcd    <= 16'h0000;
            carry   <= 4'b0000;
            tick    <= 1'b0;
            running <= 1'b0;
            flag    <= 1'b0;
        end else begin
            state   <= state_next;
            pre     <= pre_next;
            qbcd    <= qbcd_next;
            carry   <= carry_next;
            tick    <= tick_next;
            running <= (state_next == RUN);
            flag    <= flag_next;
        end
    end

endmodule

// File: tb/tb_bcd_count_sequencer.sv
// Bench for bcd_count_sequencer: two instances (wrapping /4 and stopping /1) compared
// every cycle against an integer-count reference model, plus directed and random phases.
module tb_bcd_count_sequencer;

    localparam int NDUT    = 2;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_v   [NDUT];
    logic        stop_v    [NDUT];
    logic        clear_v   [NDUT];
    logic [15:0] qbcd_v    [NDUT];
    logic [3:0]  carry_v   [NDUT];
    logic        tick_v    [NDUT];
    logic        running_v [NDUT];
    logic        flag_v    [NDUT];

    int n_cmp = 0;
    int n_err = 0;

    int m_pre  [NDUT] = '{4, 1};
    int m_lim  [NDUT] = '{9675, 9675};
    int m_wrap [NDUT] = '{1, 0};
    int m_mode [NDUT];
    int m_cnt  [NDUT];
    int m_ph   [NDUT];
    int m_tick [NDUT];
    int m_carry[NDUT];
    int m_flag [NDUT];

    always #5 clk = ~clk;

    bcd_count_sequencer #(.PRESCALE(4), .LIMIT(16'h9675), .AUTO_WRAP(1'b1)) dut_a (
        .clk(clk), .rst(rst), .start(start_v[0]), .stop(stop_v[0]), .clear(clear_v[0]),
        .qbcd(qbcd_v[0]), .carry(carry_v[0]), .tick(tick_v[0]),
        .running(running_v[0]), .flag(flag_v[0])
    );

    bcd_count_sequencer #(.PRESCALE(1), .LIMIT(16'h9675), .AUTO_WRAP(1'b0)) dut_b (
        .clk(clk), .rst(rst), .start(start_v[1]), .stop(stop_v[1]), .clear(clear_v[1]),
        .qbcd(qbcd_v[1]), .carry(carry_v[1]), .tick(tick_v[1]),
        .running(running_v[1]), .flag(flag_v[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int n);
        return {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < NDUT; d++) begin
            m_mode[d]  = M_IDLE;
            m_cnt[d]   = 0;
            m_ph[d]    = 0;
            m_tick[d]  = 0;
            m_carry[d] = 0;
            m_flag[d]  = 0;
        end
    endtask

    // Reference: integer count, phase within the tick period, operating mode
    task automatic model_step(input int d, input logic s, input logic p, input logic c);
        int pw;
        m_tick[d]  = 0;
        m_carry[d] = 0;
        if (m_wrap[d] != 0) m_flag[d] = 0;
        if (c) begin
            m_mode[d] = M_IDLE;
            m_cnt[d]  = 0;
            m_ph[d]   = 0;
            m_flag[d] = 0;
        end else if (m_mode[d] == M_RUN) begin
            if (p) begin
                m_mode[d] = M_PAUSE;
            end else if (m_ph[d] == m_pre[d] - 1) begin
                m_ph[d] = 0;
                if (m_cnt[d] == m_lim[d]) begin
                    m_flag[d] = 1;
                    if (m_wrap[d] != 0) begin
                        m_cnt[d]  = 0;
                        m_tick[d] = 1;
                    end else begin
                        m_mode[d] = M_DONE;
                    end
                end else begin
                    m_cnt[d]  = m_cnt[d] + 1;
                    m_tick[d] = 1;
                    pw = 1;
                    for (int i = 0; i < 4; i++) begin
                        pw = pw * 10;
                        if (m_cnt[d] % pw == 0) m_carry[d] = m_carry[d] | (1 << i);
                    end
                    m_cnt[d] = m_cnt[d] % 10000;
                end
            end else begin
                m_ph[d] = m_ph[d] + 1;
            end
        end else if (m_mode[d] == M_IDLE || m_mode[d] == M_PAUSE) begin
            if (!p && s) m_mode[d] = M_RUN;
        end
    endtask

    task automatic check_dut(input int d);
        check_eq($sformatf("qbcd%0d", d), 32'(qbcd_v[d]), 32'(to_bcd(m_cnt[d])));
        check_eq($sformatf("carry%0d", d), 32'(carry_v[d]), 32'(m_carry[d]));
        check_eq($sformatf("tick%0d", d), 32'(tick_v[d]), 32'(m_tick[d]));
        check_eq($sformatf("running%0d", d), 32'(running_v[d]), 32'(m_mode[d] == M_RUN));
        check_eq($sformatf("flag%0d", d), 32'(flag_v[d]), 32'(m_flag[d]));
    endtask

    task automatic set_in(input int d, input logic s, input logic p, input logic c);
        start_v[d] = s;
        stop_v[d]  = p;
        clear_v[d] = c;
    endtask

    task automatic step();
        logic s [NDUT];
        logic p [NDUT];
        logic c [NDUT];
        for (int d = 0; d < NDUT; d++) begin
            s[d] = start_v[d];
            p[d] = stop_v[d];
            c[d] = clear_v[d];
        end
        @(posedge clk);
        for (int d = 0; d < NDUT; d++) model_step(d, s[d], p[d], c[d]);
        #1;
        for (int d = 0; d < NDUT; d++) check_dut(d);
    endtask

    task automatic run_until(input int d, input int target, input int budget);
        int k;
        k = 0;
        while (m_cnt[d] != target && k < budget) begin
            step();
            k++;
        end
        if (m_cnt[d] != target) check_eq("timeout_count", 32'(m_cnt[d]), 32'(target));
    endtask

    task automatic run_to_tick(input int d, input int budget);
        int k;
        k = 0;
        step();
        while (m_tick[d] == 0 && k < budget) begin
            step();
            k++;
        end
        if (m_tick[d] == 0) check_eq("timeout_tick", 32'd0, 32'd1);
    endtask

    task automatic async_reset_check();
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check_eq("rst_qbcd", 32'(qbcd_v[d]), 32'h0);
            check_eq("rst_carry", 32'(carry_v[d]), 32'h0);
            check_eq("rst_tick", 32'(tick_v[d]), 32'h0);
            check_eq("rst_running", 32'(running_v[d]), 32'h0);
            check_eq("rst_flag", 32'(flag_v[d]), 32'h0);
        end
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < NDUT; d++) set_in(d, 1'b0, 1'b0, 1'b0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) check_dut(d);
        @(negedge clk);
        rst = 1'b0;

        // start, then ticks every 4 cycles
        set_in(0, 1'b1, 1'b0, 1'b0);
        step();
        set_in(0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k % 4 == 0) begin
                check_eq("first_ticks", 32'(tick_v[0]), 32'd1);
                check_eq("first_qbcd", 32'(qbcd_v[0]), 32'(k / 4));
            end
        end

        // pause two cycles into a period, resume continues the partial period
        step();
        step();
        set_in(0, 1'b0, 1'b1, 1'b0);
        step();
        set_in(0, 1'b0, 1'b0, 1'b0);
        repeat (10) step();
        check_eq("pause_frozen", 32'(qbcd_v[0]), 32'h0003);
        set_in(0, 1'b1, 1'b0, 1'b0);
        step();
        set_in(0, 1'b0, 1'b0, 1'b0);
        step();
        check_eq("resume_no_tick", 32'(tick_v[0]), 32'd0);
        step();
        check_eq("resume_tick", 32'(tick_v[0]), 32'd1);
        check_eq("resume_qbcd", 32'(qbcd_v[0]), 32'h0004);

        // stop and start together in RUN: pause wins
        set_in(0, 1'b1, 1'b1, 1'b0);
        step();
        check_eq("stop_wins", 32'(running_v[0]), 32'd0);
        set_in(0, 1'b1, 1'b0, 1'b0);
        step();
        set_in(0, 1'b0, 1'b0, 1'b0);

        // digit ripple 0009 -> 0010
        run_until(0, 9, 200);
        run_to_tick(0, 20);
        check_eq("ripple_qbcd", 32'(qbcd_v[0]), 32'h0010);
        check_eq("ripple_carry", 32'(carry_v[0]), 32'h1);

        // async reset mid-period at 0342
        run_until(0, 342, 2000);
        step();
        async_reset_check();
        set_in(0, 1'b1, 1'b0, 1'b0);
        step();
        set_in(0, 1'b0, 1'b0, 1'b0);

        // 0999 -> 1000
        run_until(0, 999, 5000);
        run_to_tick(0, 20);
        check_eq("ripple3_qbcd", 32'(qbcd_v[0]), 32'h1000);
        check_eq("ripple3_carry", 32'(carry_v[0]), 32'h7);

        // wrap at LIMIT
        run_until(0, 9675, 40000);
        run_to_tick(0, 20);
        check_eq("wrap_qbcd", 32'(qbcd_v[0]), 32'h0000);
        check_eq("wrap_flag", 32'(flag_v[0]), 32'd1);
        check_eq("wrap_running", 32'(running_v[0]), 32'd1);
        step();
        check_eq("wrap_flag_pulse", 32'(flag_v[0]), 32'd0);

        // clear on the tick edge suppresses the tick
        run_until(0, 5, 100);
        while (m_ph[0] != m_pre[0] - 1) step();
        set_in(0, 1'b0, 1'b0, 1'b1);
        step();
        set_in(0, 1'b0, 1'b0, 1'b0);
        check_eq("clr_tick", 32'(tick_v[0]), 32'd0);
        check_eq("clr_qbcd", 32'(qbcd_v[0]), 32'h0000);

        // stopping instance: hold at LIMIT, sticky flag, start ignored, clear recovers
        set_in(1, 1'b1, 1'b0, 1'b0);
        step();
        set_in(1, 1'b0, 1'b0, 1'b0);
        run_until(1, 9675, 12000);
        step();
        check_eq("done_qbcd", 32'(qbcd_v[1]), 32'h9675);
        check_eq("done_flag", 32'(flag_v[1]), 32'd1);
        check_eq("done_running", 32'(running_v[1]), 32'd0);
        check_eq("done_tick", 32'(tick_v[1]), 32'd0);
        set_in(1, 1'b1, 1'b0, 1'b0);
        repeat (3) step();
        check_eq("done_start_ign", 32'(running_v[1]), 32'd0);
        set_in(1, 1'b0, 1'b0, 1'b1);
        step();
        set_in(1, 1'b0, 1'b0, 1'b0);
        check_eq("done_clr_qbcd", 32'(qbcd_v[1]), 32'h0000);
        check_eq("done_clr_flag", 32'(flag_v[1]), 32'd0);

        // random command traffic on both instances
        for (int k = 0; k < 4000; k++) begin
            for (int d = 0; d < NDUT; d++)
                set_in(d, ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
                       ($urandom_range(0, 63) == 0));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
